write_data_serializer: RTL

- Downstream consumer of the write-data FIFO.
- On each write-command issue to DRAM, waits the programmed write latency (WL), pops one DATA_WIDTH entry from the FIFO and drives it onto the DQ path as BURST_LEN beats, LSB beat first.
- Tracks up to PEND_DEPTH in-flight write issues so back-to-back writes stream seamlessly.
- Reports underflow, overflow and collision errors through sticky flags.

---
 rtl/wdata_pkg.sv | 27 ++
 rtl/wr_issue_delay_queue.sv | 59 +++++
 rtl/write_data_serializer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wdata_pkg.sv
// Shared types and constants for the write-data serializer and its issue-delay queue.
package wdata_pkg;

  localparam int DEF_DATA_WIDTH = 1024;
  localparam int DEF_BEAT_WIDTH = 128;
  localparam int DEF_PEND_DEPTH = 4;
  localparam int WL_W           = 5;
  localparam int BURST_LEN      = DEF_DATA_WIDTH / DEF_BEAT_WIDTH;
  localparam int BEAT_CNT_W     = $clog2(BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } ser_state_t;

  typedef struct packed {
    logic            valid;
    logic [WL_W-1:0] cnt;
  } pend_entry_t;

  // Counter load value: WL is clamped to 2, and the entry expires two cycles early
  // relative to the raw latency so the pop lands one cycle before the first beat.
  function automatic logic [WL_W-1:0] wl_to_cnt(input logic [WL_W-1:0] wl);
    return (wl < WL_W'(2)) ? '0 : wl - WL_W'(2);
  endfunction

endpackage

// File: rtl/wr_issue_delay_queue.sv
// In-order countdown queue of pending write issues; head expires when its counter is 0.
// Latency: push visible next cycle; head_exp combinational from registered state.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module wr_issue_delay_queue
  import wdata_pkg::*;
#(
  parameter int DEPTH = DEF_PEND_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            push,
  input  logic [WL_W-1:0] push_cnt,
  input  logic            pop,
  output logic            head_exp,
  output logic            exp_next,
  output logic            full,
  output logic            not_empty
);

  pend_entry_t ent_q [DEPTH];
  pend_entry_t ent_d [DEPTH];
  logic        placed;

  assign head_exp  = ent_q[0].valid && (ent_q[0].cnt == '0);
  assign full      = ent_q[DEPTH-1].valid;
  assign not_empty = ent_q[0].valid;
  assign exp_next  = ent_d[0].valid && (ent_d[0].cnt == '0);

  always_comb begin
    placed = 1'b0;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      ent_d[DEPTH-1] = '0;
    end
    // Entries that reach 0 behind the head hold there, preserving issue order.
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_d[i].valid && ent_d[i].cnt != '0) ent_d[i].cnt = ent_d[i].cnt - WL_W'(1);
    end
    if (push && (!full || pop)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!placed && !ent_d[i].valid) begin
          ent_d[i].valid = 1'b1;
          ent_d[i].cnt   = push_cnt;
          placed         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: rtl/write_data_serializer.sv
// Pops one FIFO entry per expired write issue and streams it as BURST_LEN DQ beats, LSB first.
// Latency: pop in expiry cycle L, preamble strobe at L, beats at L+1..L+BURST_LEN.
// Backpressure: none; empty FIFO, full queue and mid-burst expiry raise sticky flags.
module write_data_serializer
  import wdata_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
  parameter int WL_WIDTH   = WL_W,
  parameter int PEND_DEPTH = DEF_PEND_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_issue,
  input  logic [WL_WIDTH-1:0]   i_wl,
  input  logic                  i_clr_err,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  output logic [BEAT_WIDTH-1:0] o_dq,
  output logic                  o_dq_valid,
  output logic                  o_dqs_en,
  output logic                  o_busy,
  output logic                  o_underflow,
  output logic                  o_issue_overflow,
  output logic                  o_collision
);

  localparam int BL  = DATA_WIDTH / BEAT_WIDTH;
  localparam int BCW = (BL > 1) ? $clog2(BL) : 1;

  ser_state_t            state_q, state_d;
  logic [BCW-1:0]        beat_q, beat_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  valid_q, valid_d;
  logic                  dqs_q, dqs_d;
  logic                  head_exp, exp_next, q_full, q_nempty;
  logic                  last_beat, collision_evt, start;

  wr_issue_delay_queue #(.DEPTH(PEND_DEPTH)) u_queue (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (i_wr_issue),
    .push_cnt  (wl_to_cnt(WL_W'(i_wl))),
    .pop       (head_exp),
    .head_exp  (head_exp),
    .exp_next  (exp_next),
    .full      (q_full),
    .not_empty (q_nempty)
  );

  assign last_beat     = (state_q == BURST) && (beat_q == BCW'(BL - 1));
  assign collision_evt = head_exp && (state_q == BURST) && !last_beat;
  assign start         = head_exp && !collision_evt;
  assign o_fifo_rd_en  = start && !i_fifo_empty;
  assign o_busy        = q_nempty || (state_q == BURST);
  assign o_dq          = shift_q[BEAT_WIDTH-1:0];
  assign o_dq_valid    = valid_q;
  assign o_dqs_en      = dqs_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BURST;
          beat_d  = '0;
          shift_d = i_fifo_empty ? '0 : i_fifo_data;
        end
      end
      BURST: begin
        if (last_beat) begin
          beat_d = '0;
          if (start) begin
            shift_d = i_fifo_empty ? '0 : i_fifo_data;
          end else begin
            state_d = IDLE;
            shift_d = shift_q >> BEAT_WIDTH;
          end
        end else begin
          beat_d  = beat_q + BCW'(1);
          shift_d = shift_q >> BEAT_WIDTH;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = start || ((state_q == BURST) && !last_beat);
    // Strobe is raised one cycle ahead of the first beat to form the preamble.
    dqs_d   = valid_d || exp_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      dqs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      dqs_q   <= dqs_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_underflow      <= 1'b0;
      o_issue_overflow <= 1'b0;
      o_collision      <= 1'b0;
    end else begin
      if (start && i_fifo_empty)      o_underflow <= 1'b1;
      else if (i_clr_err)             o_underflow <= 1'b0;
      if (i_wr_issue && q_full && !head_exp) o_issue_overflow <= 1'b1;
      else if (i_clr_err)             o_issue_overflow <= 1'b0;
      if (collision_evt)              o_collision <= 1'b1;
      else if (i_clr_err)             o_collision <= 1'b0;
    end
  end

endmodule
